// File: rtl/reciprocal_seq_pkg.sv
// Shared fixed-point parameters and FSM state type for the Q10.10 reciprocal unit.
package reciprocal_seq_pkg;

    localparam int QM    = 10;
    localparam int QN    = 10;
    localparam int WIDTH = QM + QN;

    localparam logic [WIDTH-1:0] QMAX = 20'h7FFFF;
    localparam logic [WIDTH-1:0] QMIN = 20'h80000;

    localparam logic [21:0] ONE_REM = 22'h100000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_DIV,
        S_FINISH
    } state_t;

endpackage

// File: rtl/reciprocal_seq_lzc.sv
// Leading-zero counter for the 20-bit operand magnitude. An input of zero returns 20.
module lzc
    import reciprocal_seq_pkg::*;
(
    input  logic [WIDTH-1:0] i_data,
    output logic [4:0]       o_lzc
);

    // The scan runs upward, so the highest set bit is the last one to write.
    always_comb begin
        o_lzc = 5'd20;
        for (int i = 0; i < WIDTH; i++) begin
            if (i_data[i]) begin
                o_lzc = 5'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/reciprocal_seq.sv
// Multi-cycle signed Q10.10 reciprocal: restoring division of 1.0 by |i_data|,
// with the iteration count seeded by the operand's leading-zero count.
module reciprocal_seq
    import reciprocal_seq_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_data,
    output logic             o_sat
);

    state_t           state;
    state_t           next_state;
    logic             sign;
    logic             sat;
    logic [WIDTH-1:0] mag;
    logic [WIDTH-1:0] q;
    logic [21:0]      rem;
    logic [4:0]       k;
    logic [4:0]       lzc_val;
    logic [21:0]      shifted;
    logic             fits;

    lzc u_lzc (
        .i_data (mag),
        .o_lzc  (lzc_val)
    );

    assign shifted = {2'b00, mag} << k;
    assign fits    = (shifted <= rem);
    assign o_busy  = (state != S_IDLE);

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (i_start) next_state = S_PREP;
            S_PREP:   next_state = (mag <= 20'd2) ? S_FINISH : S_DIV;
            S_DIV:    if (k == 5'd0) next_state = S_FINISH;
            S_FINISH: next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Datapath: operand capture, bit-serial quotient build, and result formatting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sign   <= 1'b0;
            sat    <= 1'b0;
            mag    <= '0;
            q      <= '0;
            rem    <= '0;
            k      <= '0;
            o_done <= 1'b0;
            o_data <= '0;
            o_sat  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        sign <= i_data[WIDTH-1];
                        mag  <= i_data[WIDTH-1] ? WIDTH'(-i_data) : i_data;
                    end
                end
                S_PREP: begin
                    sat <= (mag <= 20'd2);
                    rem <= ONE_REM;
                    q   <= '0;
                    k   <= 5'(lzc_val + 5'd1);
                end
                S_DIV: begin
                    if (fits) begin
                        rem  <= rem - shifted;
                        q[k] <= 1'b1;
                    end
                    if (k != 5'd0) begin
                        k <= k - 5'd1;
                    end
                end
                S_FINISH: begin
                    if (sat) begin
                        o_data <= sign ? QMIN : QMAX;
                    end else begin
                        o_data <= sign ? WIDTH'(-q) : q;
                    end
                    o_sat  <= sat;
                    o_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
